wishbone_arbiter: RTL and testbench

- Shares one wishbone slave between NUM_MASTERS wishbone masters using round-robin arbitration. The grant is held for the whole bus cycle, i.e. while the granted master keeps cyc_o high.
- Sits between master interfaces and the slave interface wherever two or more masters target one peripheral, in place of a point-to-point intercon.
- Includes a watchdog that aborts stalled transfers with err.

---
 rtl/wishbone_arb_pkg.sv | 28 ++
 rtl/wishbone_arb_if.sv | 63 ++++++
 rtl/wishbone_arbiter_picker.sv | 30 +++
 rtl/wishbone_arbiter.sv | 152 +++++++++++++++
 tb/tb_wishbone_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wishbone_arb_pkg.sv
// Shared types and helpers for the round-robin wishbone arbiter.
// Bus widths live here so interfaces, RTL and bench agree.
package wishbone_arb_pkg;

  localparam int MAX_MASTERS = 8;
  localparam int WB_AW       = 32;
  localparam int WB_DW       = 32;
  localparam int WB_SW       = WB_DW / 8;
  localparam int WB_TW       = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ABORT = 2'd2
  } arb_state_t;

  function automatic logic [2:0] onehot_to_index(
    input logic [MAX_MASTERS-1:0] oh
  );
    logic [2:0] r;
    r = '0;
    for (int i = 0; i < MAX_MASTERS; i++) begin
      if (oh[i]) r = r | 3'(i);
    end
    return r;
  endfunction

endpackage

// File: rtl/wishbone_arb_if.sv
// Wishbone master-side and slave-side bundles.
// The intercon modports are the views the arbiter takes.
interface wishboneMaster;
  import wishbone_arb_pkg::*;

  logic             cyc_o;
  logic             stb_o;
  logic             we_o;
  logic [WB_SW-1:0] sel_o;
  logic [WB_AW-1:0] adr_o;
  logic [WB_DW-1:0] dat_o;
  logic [WB_TW-1:0] tga_o;
  logic [WB_TW-1:0] tgc_o;
  logic [WB_TW-1:0] tgd_o;
  logic             ack_i;
  logic             err_i;
  logic             rty_i;
  logic [WB_DW-1:0] dat_i;
  logic [WB_TW-1:0] tgd_i;

  modport master (
    output cyc_o, stb_o, we_o, sel_o, adr_o,
    output dat_o, tga_o, tgc_o, tgd_o,
    input  ack_i, err_i, rty_i, dat_i, tgd_i
  );

  modport intercon (
    input  cyc_o, stb_o, we_o, sel_o, adr_o,
    input  dat_o, tga_o, tgc_o, tgd_o,
    output ack_i, err_i, rty_i, dat_i, tgd_i
  );
endinterface

interface wishboneSlave;
  import wishbone_arb_pkg::*;

  logic             cyc_i;
  logic             stb_i;
  logic             we_i;
  logic [WB_SW-1:0] sel_i;
  logic [WB_AW-1:0] adr_i;
  logic [WB_DW-1:0] dat_i;
  logic [WB_TW-1:0] tga_i;
  logic [WB_TW-1:0] tgc_i;
  logic [WB_TW-1:0] tgd_i;
  logic             ack_o;
  logic             err_o;
  logic             rty_o;
  logic [WB_DW-1:0] dat_o;
  logic [WB_TW-1:0] tgd_o;

  modport slave (
    input  cyc_i, stb_i, we_i, sel_i, adr_i,
    input  dat_i, tga_i, tgc_i, tgd_i,
    output ack_o, err_o, rty_o, dat_o, tgd_o
  );

  modport intercon (
    output cyc_i, stb_i, we_i, sel_i, adr_i,
    output dat_i, tga_i, tgc_i, tgd_i,
    input  ack_o, err_o, rty_o, dat_o, tgd_o
  );
endinterface

// File: rtl/wishbone_arbiter_picker.sv
// Round-robin picker: first requester at or after the pointer,
// wrapping modulo NUM_MASTERS. Purely combinational.
module rr_priority_picker
  import wishbone_arb_pkg::*;
#(
  parameter  int NUM_MASTERS = 2,
  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic [NUM_MASTERS-1:0] i_req,
  input  logic [IW-1:0]          i_ptr,
  output logic [NUM_MASTERS-1:0] o_gnt,
  output logic [IW-1:0]          o_idx,
  output logic                   o_valid
);

  // Scan from the pointer and keep the first hit.
  always_comb begin
    o_gnt   = '0;
    o_valid = 1'b0;
    for (int k = 0; k < NUM_MASTERS; k++) begin
      if (!o_valid && i_req[(int'(i_ptr) + k) % NUM_MASTERS]) begin
        o_valid = 1'b1;
        o_gnt[(int'(i_ptr) + k) % NUM_MASTERS] = 1'b1;
      end
    end
  end

  assign o_idx = IW'(onehot_to_index(MAX_MASTERS'(o_gnt)));

endmodule

// File: rtl/wishbone_arbiter.sv
// Round-robin share of one wishbone slave among several masters,
// with a watchdog that aborts stalled strobes with err.
module wishbone_arbiter
  import wishbone_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  wishboneMaster.intercon        master [NUM_MASTERS],
  wishboneSlave.intercon         slave,
  output logic [NUM_MASTERS-1:0] grant_o,
  output logic                   timeout_o
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 0) ?
                      $clog2(TIMEOUT_CYCLES + 1) : 1;

  arb_state_t             r_state;
  logic [NUM_MASTERS-1:0] r_grant;
  logic [IW-1:0]          r_idx;
  logic [IW-1:0]          r_ptr;

  logic [NUM_MASTERS-1:0] w_cyc;
  logic [NUM_MASTERS-1:0] w_stb;
  logic [NUM_MASTERS-1:0] w_we;
  logic [WB_SW-1:0]       w_sel [NUM_MASTERS];
  logic [WB_AW-1:0]       w_adr [NUM_MASTERS];
  logic [WB_DW-1:0]       w_dat [NUM_MASTERS];
  logic [WB_TW-1:0]       w_tga [NUM_MASTERS];
  logic [WB_TW-1:0]       w_tgc [NUM_MASTERS];
  logic [WB_TW-1:0]       w_tgd [NUM_MASTERS];

  logic [NUM_MASTERS-1:0] w_pick_gnt;
  logic [IW-1:0]          w_pick_idx;
  logic                   w_pick_vld;
  logic [IW-1:0]          w_nxt_ptr;
  logic                   w_route;
  logic                   w_resp;
  logic                   w_stall;
  logic                   w_to;

  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_m
    assign w_cyc[g] = master[g].cyc_o;
    assign w_stb[g] = master[g].stb_o;
    assign w_we[g]  = master[g].we_o;
    assign w_sel[g] = master[g].sel_o;
    assign w_adr[g] = master[g].adr_o;
    assign w_dat[g] = master[g].dat_o;
    assign w_tga[g] = master[g].tga_o;
    assign w_tgc[g] = master[g].tgc_o;
    assign w_tgd[g] = master[g].tgd_o;

    assign master[g].ack_i = w_route & r_grant[g] & slave.ack_o;
    assign master[g].err_i = w_route & r_grant[g] &
                             (slave.err_o | w_to);
    assign master[g].rty_i = w_route & r_grant[g] & slave.rty_o;
    assign master[g].dat_i = slave.dat_o;
    assign master[g].tgd_i = slave.tgd_o;
  end

  rr_priority_picker #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_pick (
    .i_req   (w_cyc),
    .i_ptr   (r_ptr),
    .o_gnt   (w_pick_gnt),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_vld)
  );

  assign w_route   = (r_state == GRANT);
  assign w_resp    = slave.ack_o | slave.err_o | slave.rty_o;
  assign w_stall   = w_route & w_stb[r_idx] & ~w_resp;
  assign w_nxt_ptr = (r_idx == IW'(NUM_MASTERS - 1)) ?
                     '0 : r_idx + 1'b1;

  assign slave.cyc_i = w_route & w_cyc[r_idx] & ~w_to;
  assign slave.stb_i = w_route & w_stb[r_idx] & ~w_to;
  assign slave.we_i  = w_route & w_we[r_idx];
  assign slave.sel_i = w_route ? w_sel[r_idx] : '0;
  assign slave.adr_i = w_route ? w_adr[r_idx] : '0;
  assign slave.dat_i = w_route ? w_dat[r_idx] : '0;
  assign slave.tga_i = w_route ? w_tga[r_idx] : '0;
  assign slave.tgc_i = w_route ? w_tgc[r_idx] : '0;
  assign slave.tgd_i = w_route ? w_tgd[r_idx] : '0;

  assign grant_o   = r_grant;
  assign timeout_o = w_to;

  if (TIMEOUT_CYCLES > 0) begin : g_wd
    logic [CW-1:0] r_cnt;

    // Count consecutive unanswered strobe cycles of the owner.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        r_cnt <= '0;
      end else if (w_stall && !w_to) begin
        r_cnt <= r_cnt + 1'b1;
      end else begin
        r_cnt <= '0;
      end
    end

    assign w_to = w_stall && (r_cnt == CW'(TIMEOUT_CYCLES - 1));
  end else begin : g_nowd
    assign w_to = 1'b0;
  end

  // Ownership FSM: pick in IDLE, hold for the bus cycle, release.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_idx   <= '0;
      r_ptr   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_pick_vld) begin
            r_state <= GRANT;
            r_grant <= w_pick_gnt;
            r_idx   <= w_pick_idx;
          end
        end
        GRANT: begin
          if (w_to) begin
            r_state <= ABORT;
          end else if (!w_cyc[r_idx]) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_ptr   <= w_nxt_ptr;
          end
        end
        ABORT: begin
          if (!w_cyc[r_idx]) begin
            r_state <= IDLE;
            r_grant <= '0;
            r_ptr   <= w_nxt_ptr;
          end
        end
        default: begin
          r_state <= IDLE;
          r_grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Bench for wishbone_arbiter: directed scenarios with literal
// expectations plus random traffic against an ownership model.
module tb_wishbone_arbiter;
  import wishbone_arb_pkg::*;

  localparam int NM = 3;
  localparam int T  = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NM-1:0]    tcyc, tstb, twe;
  logic [WB_SW-1:0] tsel [NM];
  logic [WB_AW-1:0] tadr [NM];
  logic [WB_DW-1:0] tdat [NM];
  logic [WB_TW-1:0] ttga [NM];
  logic [WB_TW-1:0] ttgc [NM];
  logic [WB_TW-1:0] ttgd [NM];
  logic             sack, serr, srty;
  logic [WB_DW-1:0] sdat;
  logic [WB_TW-1:0] stgd;

  logic [NM-1:0]    mack, merr, mrty;
  logic [WB_DW-1:0] mdat [NM];
  logic [WB_TW-1:0] mtgd [NM];
  logic [NM-1:0]    grant;
  logic             tmo;

  wishboneMaster m [NM] ();
  wishboneSlave  s ();

  for (genvar g = 0; g < NM; g++) begin : g_b
    assign m[g].cyc_o = tcyc[g];
    assign m[g].stb_o = tstb[g];
    assign m[g].we_o  = twe[g];
    assign m[g].sel_o = tsel[g];
    assign m[g].adr_o = tadr[g];
    assign m[g].dat_o = tdat[g];
    assign m[g].tga_o = ttga[g];
    assign m[g].tgc_o = ttgc[g];
    assign m[g].tgd_o = ttgd[g];
    assign mack[g]    = m[g].ack_i;
    assign merr[g]    = m[g].err_i;
    assign mrty[g]    = m[g].rty_i;
    assign mdat[g]    = m[g].dat_i;
    assign mtgd[g]    = m[g].tgd_i;
  end

  assign s.ack_o = sack;
  assign s.err_o = serr;
  assign s.rty_o = srty;
  assign s.dat_o = sdat;
  assign s.tgd_o = stgd;

  wishbone_arbiter #(
    .NUM_MASTERS    (NM),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk_i     (clk),
    .rst_n_i   (rst_n),
    .master    (m),
    .slave     (s),
    .grant_o   (grant),
    .timeout_o (tmo)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp,
               $time);
    end
  endtask

  // Behavioural model: who owns the bus, whether aborted,
  // round-robin start, and how long the owner has stalled.
  int mo  = -1;
  bit mab = 1'b0;
  int mp  = 0;
  int mst = 0;

  function automatic int first_req(input logic [NM-1:0] r,
                                   input int p);
    for (int k = 0; k < NM; k++) begin
      if (r[(p + k) % NM]) return (p + k) % NM;
    end
    return -1;
  endfunction

  initial begin : model
    bit rsp;
    forever begin
      @(posedge clk or negedge rst_n);
      rsp = sack | serr | srty;
      if (!rst_n) begin
        mo = -1; mab = 1'b0; mp = 0; mst = 0;
      end else if (mo < 0) begin
        mo = first_req(tcyc, mp);
        mst = 0;
      end else if (mab) begin
        if (!tcyc[mo]) begin
          mp = (mo + 1) % NM; mo = -1; mab = 1'b0;
        end
      end else if (tstb[mo] && !rsp && mst + 1 == T) begin
        mab = 1'b1; mst = 0;
      end else if (!tcyc[mo]) begin
        mp = (mo + 1) % NM; mo = -1; mst = 0;
      end else begin
        mst = (tstb[mo] && !rsp) ? mst + 1 : 0;
      end
    end
  end

  initial begin : cmp
    logic [NM-1:0] eg, eack, eerr, erty;
    logic eto, ecyc, estb, ewe, route, rsp;
    logic [WB_SW-1:0] esel;
    logic [WB_AW-1:0] eadr;
    logic [WB_DW-1:0] edat;
    logic [WB_TW-1:0] etga, etgc, etgd;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_grant", grant, 0);
        chk("rst_scyc", s.cyc_i, 0);
      end else begin
        eg = '0; eack = '0; eerr = '0; erty = '0;
        eto = 0; ecyc = 0; estb = 0; ewe = 0; route = 0;
        esel = '0; eadr = '0; edat = '0;
        etga = '0; etgc = '0; etgd = '0;
        if (mo >= 0) begin
          eg[mo] = 1'b1;
          if (!mab) begin
            route = 1'b1;
            rsp = sack | serr | srty;
            eto = tstb[mo] && !rsp && (mst + 1 == T);
            ecyc = tcyc[mo] && !eto;
            estb = tstb[mo] && !eto;
            eack[mo] = sack;
            eerr[mo] = serr || eto;
            erty[mo] = srty;
            ewe = twe[mo]; esel = tsel[mo]; eadr = tadr[mo];
            edat = tdat[mo]; etga = ttga[mo];
            etgc = ttgc[mo]; etgd = ttgd[mo];
          end
        end
        chk("grant", grant, eg);
        chk("timeout", tmo, eto);
        chk("s_cyc", s.cyc_i, ecyc);
        chk("s_stb", s.stb_i, estb);
        chk("s_we", s.we_i, ewe);
        chk("s_sel", s.sel_i, esel);
        chk("s_adr", s.adr_i, eadr);
        chk("s_dat", s.dat_i, edat);
        chk("s_tga", s.tga_i, etga);
        chk("s_tgc", s.tgc_i, etgc);
        chk("s_tgd", s.tgd_i, etgd);
        chk("m_ack", mack, eack);
        chk("m_err", merr, eerr);
        chk("m_rty", mrty, erty);
        for (int i = 0; i < NM; i++) begin
          chk("m_dat", mdat[i], sdat);
          chk("m_tgd", mtgd[i], stgd);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    tcyc = '0; tstb = '0; twe = '0;
    sack = 0; serr = 0; srty = 0; sdat = '0; stgd = '0;
    for (int i = 0; i < NM; i++) begin
      tsel[i] = '0; tadr[i] = '0; tdat[i] = '0;
      ttga[i] = '0; ttgc[i] = '0; ttgd[i] = '0;
    end
  endtask

  task automatic reset_dut();
    step();
    idle_inputs();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin : main
    int w;
    bit found;
    bit quiet;
    rst_n = 1'b0;
    idle_inputs();

    // Single read by master 0, slave acks in second grant cycle.
    reset_dut();
    tcyc[0] = 1; tstb[0] = 1; tadr[0] = 32'h100;
    @(negedge clk); chk("t1_idle", grant, 0);
    step();
    @(negedge clk); chk("t1_grant", grant, 3'b001);
    chk("t1_scyc", s.cyc_i, 1);
    chk("t1_sadr", s.adr_i, 32'h100);
    step(); sack = 1; sdat = 32'hDEADBEEF;
    @(negedge clk); chk("t1_ack", mack, 3'b001);
    chk("t1_dat", mdat[0], 32'hDEADBEEF);
    step(); sack = 0; tcyc[0] = 0; tstb[0] = 0;
    @(negedge clk); chk("t1_hold", grant, 3'b001);
    step();
    @(negedge clk); chk("t1_rel", grant, 0);

    // Contention from reset alternates 0,1,0,1.
    reset_dut();
    tcyc[0] = 1; tcyc[1] = 1;
    for (int k = 0; k < 4; k++) begin
      found = 0;
      w = 0;
      while (!found && w < 6) begin
        step();
        @(negedge clk);
        if (grant != 0) found = 1;
        else w++;
      end
      chk("t2_found", found, 1);
      chk("t2_lat", w, 0);
      chk("t2_order", grant, (k % 2 == 0) ? 3'b001 : 3'b010);
      step(); tcyc[k % 2] = 0;
      step(); tcyc[k % 2] = 1;
      @(negedge clk); chk("t2_gap", grant, 0);
    end

    // Master 1 holds the bus over 4 acked strobes.
    reset_dut();
    tcyc[1] = 1;
    step();
    @(negedge clk); chk("t3_g1", grant, 3'b010);
    step(); tcyc[0] = 1;
    for (int j = 0; j < 8; j++) begin
      tstb[1] = 1; sack = j[0];
      @(negedge clk);
      chk("t3_m0ack", mack[0], 0);
      chk("t3_m1ack", mack[1], j[0]);
      chk("t3_own", grant, 3'b010);
      step();
    end
    sack = 0; tstb[1] = 0; tcyc[1] = 0;
    @(negedge clk); chk("t3_last", grant, 3'b010);
    step();
    @(negedge clk); chk("t3_idle", grant, 0);
    step();
    @(negedge clk); chk("t3_g0", grant, 3'b001);

    // Slave never answers: abort on the 8th stalled cycle.
    reset_dut();
    tcyc[0] = 1; tstb[0] = 1;
    for (int k = 1; k <= T; k++) begin
      step();
      @(negedge clk);
      chk("t4_err", merr[0], k == T);
      chk("t4_to", tmo, k == T);
      chk("t4_scyc", s.cyc_i, k != T);
    end
    step();
    @(negedge clk);
    chk("t4_ab_err", merr[0], 0);
    chk("t4_ab_to", tmo, 0);
    chk("t4_ab_scyc", s.cyc_i, 0);
    chk("t4_ab_g", grant, 3'b001);
    step(); tcyc[0] = 0; tstb[0] = 0;
    @(negedge clk); chk("t4_ab_g2", grant, 3'b001);
    step();
    @(negedge clk); chk("t4_idle", grant, 0);

    // Ack on the 8th strobe cycle wins over the watchdog.
    reset_dut();
    tcyc[0] = 1; tstb[0] = 1;
    for (int k = 1; k <= T; k++) begin
      step();
      sack = (k == T);
      @(negedge clk);
      chk("t5_to", tmo, 0);
      chk("t5_err", merr[0], 0);
    end
    chk("t5_ack", mack[0], 1);
    step(); sack = 0;
    @(negedge clk);
    chk("t5_to2", tmo, 0);
    chk("t5_scyc", s.cyc_i, 1);

    // Asynchronous reset in GRANT, pointer restarts at 0.
    reset_dut();
    tcyc[0] = 1;
    step(); tcyc[0] = 0;
    step(); tcyc[1] = 1; tstb[1] = 1;
    step();
    @(negedge clk); chk("t6_g1", grant, 3'b010);
    #1 rst_n = 1'b0;
    #1;
    chk("t6_async_g", grant, 0);
    chk("t6_async_cyc", s.cyc_i, 0);
    #1 rst_n = 1'b1;
    tcyc[0] = 1;
    step();
    @(negedge clk); chk("t6_ptr0", grant, 3'b001);

    // Random traffic, with stretches of a silent slave.
    reset_dut();
    quiet = 0;
    for (int c = 0; c < 3000; c++) begin
      step();
      if (c % 60 == 0) quiet = $urandom_range(0, 1);
      for (int i = 0; i < NM; i++) begin
        if (!tcyc[i]) tcyc[i] = ($urandom_range(0, 3) == 0);
        else if ($urandom_range(0, 7) == 0) tcyc[i] = 0;
        tstb[i] = tcyc[i] && ($urandom_range(0, 7) != 0);
        twe[i]  = $urandom_range(0, 1);
        tsel[i] = WB_SW'($urandom);
        tadr[i] = $urandom;
        tdat[i] = $urandom;
        ttga[i] = WB_TW'($urandom);
        ttgc[i] = WB_TW'($urandom);
        ttgd[i] = WB_TW'($urandom);
      end
      w = quiet ? 9 : $urandom_range(0, 5);
      sack = (w == 0);
      serr = (w == 1);
      srty = (w == 2);
      sdat = $urandom;
      stgd = WB_TW'($urandom);
    end
    step();
    idle_inputs();
    step();
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
